// File: rtl/cms_pkg.sv
// Shared definitions for the trace stream receiver: the WFI opcode that halts
// capture, the receiver FSM state type and the default PC width.
package cms_pkg;

    localparam int          DEFAULT_XLEN    = 64;
    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        HALTED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout whenever the
// FIFO is not empty, and a pop simply advances to the next entry.
module trace_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // An empty FIFO presents zeros, so stale storage never leaks to the output.
    assign dout = empty ? '0 : mem[rd_ptr];

    // Storage write.
    // NOTE: the storage array is deliberately not reset; the count and the empty
    // gating on dout make its contents irrelevant until written, and leaving it
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers are AW bits wide and wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_stream_receiver.sv
// Receives {pc, instr} trace beats over an AXI-Stream style port, buffers them
// for a consumer, tracks packet statistics and halts capture after a WFI beat
// that closes a packet.
module trace_stream_receiver
    import cms_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int AXI_DATA_WIDTH = XLEN + 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      S_AXIS_tvalid,
    output logic                      S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                      S_AXIS_tlast,
    input  logic [31:0]               tlast_interval,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_instr,
    output logic                      out_last,
    output logic [31:0]               pkt_count,
    output logic [31:0]               last_pkt_len,
    output logic                      overlength_err,
    output logic                      wfi_seen,
    output logic                      halted,
    input  logic                      clr
);

    localparam int FW = XLEN + 32 + 1;

    rx_state_t      state_q;
    rx_state_t      state_d;
    logic [31:0]    beat_cnt;
    logic [31:0]    pkt_count_q;
    logic           fifo_empty;
    logic           fifo_full;
    logic [FW-1:0]  fifo_dout;
    logic           accept;
    logic           is_wfi;
    logic           ovl_set;

    // rst_n gates tready so the port refuses beats for the whole reset interval,
    // not just after the first clock.
    assign S_AXIS_tready = rst_n && en && !fifo_full && (state_q != HALTED);
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;
    assign is_wfi        = (S_AXIS_tdata[31:0] == WFI_INSTRUCTION);
    assign ovl_set       = accept && !S_AXIS_tlast && (tlast_interval != 32'd0) &&
                           ({1'b0, beat_cnt} + 33'd1 >= {1'b0, tlast_interval});

    assign out_valid = !fifo_empty;
    assign {out_last, out_pc, out_instr} = fifo_dout;
    assign pkt_count = pkt_count_q;
    assign halted    = (state_q == HALTED);

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({S_AXIS_tlast, S_AXIS_tdata[XLEN+31:0]}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: packet framing, WFI halt and clear-to-resume.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (S_AXIS_tlast && is_wfi) begin
                        state_d = HALTED;
                    end else if (!S_AXIS_tlast) begin
                        state_d = IN_PKT;
                    end
                end
            end
            IN_PKT: begin
                if (accept && S_AXIS_tlast) begin
                    state_d = is_wfi ? HALTED : IDLE;
                end
            end
            HALTED: begin
                if (clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet statistics: running beat count, completed packets, last length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt     <= '0;
            pkt_count_q  <= '0;
            last_pkt_len <= '0;
        end else if (accept) begin
            if (S_AXIS_tlast) begin
                last_pkt_len <= beat_cnt + 32'd1;
                beat_cnt     <= '0;
                pkt_count_q  <= pkt_count_q + 32'd1;
            end else begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end

    // Sticky status flags; a set event in the same cycle as clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlength_err <= 1'b0;
            wfi_seen       <= 1'b0;
        end else begin
            if (ovl_set) begin
                overlength_err <= 1'b1;
            end else if (clr) begin
                overlength_err <= 1'b0;
            end
            if (accept && is_wfi) begin
                wfi_seen <= 1'b1;
            end else if (clr) begin
                wfi_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Scoreboard bench: a behavioural model predicts acceptance, packet statistics
// and flags from the stimulus; a monitor compares every presented output beat
// against the queue of beats the model expects to be buffered.
module tb_trace_stream_receiver;
    import cms_pkg::*;

    localparam int XLEN  = 64;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              tvalid;
    logic              tready;
    logic [XLEN+31:0]  tdata;
    logic              tlast;
    logic [31:0]       tlast_interval;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic              out_last;
    logic [31:0]       pkt_count;
    logic [31:0]       last_pkt_len;
    logic              overlength_err;
    logic              wfi_seen;
    logic              halted;
    logic              clr;

    trace_stream_receiver #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .S_AXIS_tvalid  (tvalid),
        .S_AXIS_tready  (tready),
        .S_AXIS_tdata   (tdata),
        .S_AXIS_tlast   (tlast),
        .tlast_interval (tlast_interval),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_last       (out_last),
        .pkt_count      (pkt_count),
        .last_pkt_len   (last_pkt_len),
        .overlength_err (overlength_err),
        .wfi_seen       (wfi_seen),
        .halted         (halted),
        .clr            (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            last;
    } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    beat_t       sb[$];
    int unsigned m_beat;
    logic [31:0] m_pkt;
    logic [31:0] m_len;
    bit          m_ovl;
    bit          m_wfi;
    bit          m_halted;
    bit          m_tready;
    bit          m_accept;
    beat_t       m_in;
    beat_t       m_head;

    // Inputs change shortly after posedge, so at negedge they are exactly what
    // the next posedge will sample: compare the present, then predict the edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_beat = 0; m_pkt = '0; m_len = '0;
            m_ovl = 0; m_wfi = 0; m_halted = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_tready", tready, 0);
            check("rst_out_fields", {out_pc, out_instr[0], out_last}, 0);
            check("rst_pkt_count", pkt_count, 0);
            check("rst_flags", {overlength_err, wfi_seen, halted}, 0);
        end else begin
            m_tready = en && (sb.size() < DEPTH) && !m_halted;
            check("tready", tready, m_tready);
            check("out_valid", out_valid, sb.size() != 0);
            check("pkt_count", pkt_count, m_pkt);
            check("last_pkt_len", last_pkt_len, m_len);
            check("overlength_err", overlength_err, m_ovl);
            check("wfi_seen", wfi_seen, m_wfi);
            check("halted", halted, m_halted);

            // monitor: whatever the DUT presents must be the oldest expected beat
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("beat_underflow", 1, 0);
                end else begin
                    m_head = sb[0];
                    check("out_pc", out_pc, m_head.pc);
                    check("out_instr", out_instr, m_head.instr);
                    check("out_last", out_last, m_head.last);
                end
            end
            if (sb.size() != 0 && out_ready) begin
                void'(sb.pop_front());
            end

            if (clr) begin
                m_ovl = 0;
                m_wfi = 0;
                if (m_halted) m_halted = 0;
            end
            m_accept = tvalid && m_tready;
            if (m_accept) begin
                m_in.pc    = tdata[XLEN+31:32];
                m_in.instr = tdata[31:0];
                m_in.last  = tlast;
                sb.push_back(m_in);
                if (m_in.instr == WFI_INSTRUCTION) m_wfi = 1;
                if (tlast) begin
                    m_len  = m_beat + 1;
                    m_beat = 0;
                    m_pkt  = m_pkt + 32'd1;
                    if (m_in.instr == WFI_INSTRUCTION) m_halted = 1;
                end else begin
                    if (tlast_interval != 0 && m_beat + 1 >= tlast_interval) m_ovl = 1;
                    m_beat = m_beat + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rand_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == WFI_INSTRUCTION) v = v ^ 32'h1;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic send_beat(input logic [63:0] pc, input logic [31:0] instr, input logic last);
        bit done;
        done   = 0;
        tvalid = 1'b1;
        tdata  = {pc, instr};
        tlast  = last;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (tready) done = 1;
            next_cycle();
        end
        if (!done) check("send_timeout", 0, 1);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0; en = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        tlast_interval = '0; out_ready = 1'b0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        next_cycle();

        // three-beat packet passes through in order
        send_beat(64'h100, 32'h0000_0013, 1'b0);
        send_beat(64'h104, 32'h0000_0093, 1'b0);
        send_beat(64'h108, 32'h0000_0113, 1'b1);
        idle_cycles(4);
        check("s1_pkt_count", pkt_count, 1);
        check("s1_last_len", last_pkt_len, 3);

        // backpressure: exactly DEPTH accepts, then one more per pop
        out_ready = 1'b0;
        tvalid = 1'b1;
        tlast = 1'b0;
        tdata = {{$urandom, $urandom}, rand_instr()};
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tready) acc++;
            next_cycle();
            tdata = {{$urandom, $urandom}, rand_instr()};
        end
        check("s2_fill_accepts", acc, 8);
        out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (tready) acc++;
            next_cycle();
            out_ready = 1'b0;
            tdata = {{$urandom, $urandom}, rand_instr()};
        end
        check("s2_after_pop_accepts", acc, 1);
        tvalid = 1'b0;
        out_ready = 1'b1;
        idle_cycles(10);
        check("s2_drained", out_valid, 0);
        send_beat(64'h200, rand_instr(), 1'b1);
        check("s2_last_len", last_pkt_len, 10);

        // overlength detection at the 4th non-last beat, then clear
        tlast_interval = 32'd4;
        for (int i = 1; i <= 5; i++) begin
            send_beat(64'h300 + 64'(4 * i), rand_instr(), 1'b0);
            if (i == 3) check("s3_ovl_before", overlength_err, 0);
            if (i == 4) check("s3_ovl_at_4th", overlength_err, 1);
        end
        pulse_clr();
        check("s3_ovl_cleared", overlength_err, 0);
        send_beat(64'h400, rand_instr(), 1'b1);
        tlast_interval = '0;
        idle_cycles(2);

        // WFI closes a packet and halts capture while the buffer drains
        out_ready = 1'b0;
        send_beat(64'h500, rand_instr(), 1'b0);
        send_beat(64'h504, rand_instr(), 1'b0);
        send_beat(64'h508, WFI_INSTRUCTION, 1'b1);
        check("s4_halted", halted, 1);
        check("s4_wfi_seen", wfi_seen, 1);
        check("s4_tready_low", tready, 0);
        check("s4_buffered", out_valid, 1);
        out_ready = 1'b1;
        tvalid = 1'b1;
        idle_cycles(6);
        tvalid = 1'b0;
        check("s4_drained", out_valid, 0);
        check("s4_still_halted", halted, 1);
        pulse_clr();
        check("s4_resumed", halted, 0);
        check("s4_tready_back", tready, 1);

        // asynchronous reset mid-packet discards the partial packet
        out_ready = 1'b0;
        send_beat(64'h600, rand_instr(), 1'b0);
        send_beat(64'h604, rand_instr(), 1'b0);
        rst_n = 1'b0;
        #1;
        check("s5_async_out_valid", out_valid, 0);
        check("s5_async_tready", tready, 0);
        check("s5_async_pc", out_pc, 0);
        check("s5_async_instr", out_instr, 0);
        check("s5_async_counts", {pkt_count, last_pkt_len}, 0);
        check("s5_async_flags", {out_last, overlength_err, wfi_seen, halted}, 0);
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        next_cycle();
        send_beat(64'h700, rand_instr(), 1'b0);
        send_beat(64'h704, rand_instr(), 1'b1);
        check("s5_new_len", last_pkt_len, 2);

        // packet counter wraps at 2^32
        dut.pkt_count_q = 32'hFFFF_FFFF;
        m_pkt = 32'hFFFF_FFFF;
        next_cycle();
        send_beat(64'h800, rand_instr(), 1'b1);
        check("s6_pkt_wrap", pkt_count, 0);
        idle_cycles(2);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (c % 50 == 0) tlast_interval = $urandom_range(0, 6);
            tvalid    = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tlast     = ($urandom_range(0, 4) == 0);
            clr       = ($urandom_range(0, 19) == 0);
            tdata     = {{$urandom, $urandom},
                         ($urandom_range(0, 29) == 0) ? WFI_INSTRUCTION : rand_instr()};
            next_cycle();
        end
        tvalid = 1'b0; tlast = 1'b0; clr = 1'b0; en = 1'b1; out_ready = 1'b1;
        idle_cycles(12);
        check("final_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/trace_stream_receiver.md
TRACE_STREAM_RECEIVER -- requirements
Module: trace_stream_receiver

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default XLEN+32, meaning stream beat width, formatted as {pc, instr}.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of buffered beats (a power of 2, at least 2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have en  input  1  receive enable; when low, no beats are accepted.
REQ-007 SHALL have S_AXIS_tvalid  input  1  upstream beat valid.
REQ-008 SHALL have S_AXIS_tready  output  1  beat accept.
REQ-009 SHALL have S_AXIS_tdata  input  AXI_DATA_WIDTH  {pc[XLEN-1:0], instr[31:0]}.
REQ-010 SHALL have S_AXIS_tlast  input  1  packet end.
REQ-011 SHALL have tlast_interval  input  32  expected maximum beats per packet; 0 disables the check.
REQ-012 SHALL have out_valid / out_ready  output / input  1 / 1  consumer handshake.
REQ-013 SHALL have out_pc, out_instr, out_last  outputs  XLEN / 32 / 1  head-of-buffer beat.
REQ-014 SHALL have pkt_count  output  32  completed packets, wrapping at 2^32.
REQ-015 SHALL have last_pkt_len  output  32  beat count of the most recently completed packet, including its tlast beat.
REQ-016 SHALL have overlength_err, wfi_seen, halted  outputs  1 each  sticky status flags.
REQ-017 SHALL have clr  input  1  synchronous clear of the status flags and resume from HALTED.

Function
REQ-018 S_AXIS_tready SHALL equal en AND (count < FIFO_DEPTH) AND (state != HALTED), decoded combinationally from registered state.
REQ-019 A beat is accepted only on a clock edge where tvalid AND tready are both high; tdata and tlast SHALL be stored together.
REQ-020 The buffer SHALL be show-ahead: a beat accepted into an empty buffer at edge N presents out_valid=1 with its fields after edge N (1-cycle latency).
REQ-021 The head SHALL pop on an edge where out_valid AND out_ready are both high; the out_* fields SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 A simultaneous push and pop SHALL leave count unchanged; when full, tready=0, so no push occurs even if a pop happens in the same cycle.
REQ-023 count SHALL be clog2(FIFO_DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The FSM SHALL have three states: IDLE, IN_PKT and HALTED.
REQ-025 In IDLE, accepting a non-last beat SHALL go to IN_PKT; accepting a last beat SHALL stay in IDLE.
REQ-026 In IN_PKT, accepting a last beat SHALL go to IDLE.
REQ-027 From IDLE or IN_PKT, accepting a beat with tlast=1 and instr=WFI_INSTRUCTION (0x10500073) SHALL go to HALTED.
REQ-028 In HALTED, clr=1 SHALL go to IDLE; the buffer SHALL continue draining to the consumer while HALTED.
REQ-029 beat_cnt (32-bit, internal) SHALL increment on each accepted beat; on an accepted last beat, last_pkt_len SHALL take beat_cnt+1, beat_cnt SHALL clear, and pkt_count SHALL increment.
REQ-030 overlength_err SHALL set when tlast_interval != 0 and a non-last beat is accepted with beat_cnt+1 >= tlast_interval.
REQ-031 wfi_seen SHALL set on any accepted beat whose instr equals WFI_INSTRUCTION.
REQ-032 halted SHALL equal (state == HALTED).
REQ-033 clr SHALL clear overlength_err and wfi_seen; if clr coincides with a setting event in the same cycle, set SHALL win.
REQ-034 Deasserting en SHALL NOT flush the buffer or the counters; the consumer side SHALL keep operating.

Reset
REQ-035 While rst_n=0, the following SHALL apply immediately and independently of clk: buffer empty, out_valid=0, S_AXIS_tready=0, out_pc=0, out_instr=0, out_last=0, pkt_count=0, last_pkt_len=0, beat_cnt=0, all flags 0, state IDLE.
REQ-036 A reset asserted mid-packet SHALL discard the partial packet; the first beat after release SHALL count as beat 1 of a new packet.

Structure
REQ-037 Package cms_pkg SHALL hold WFI_INSTRUCTION, the FSM state type and the default XLEN.
REQ-038 Buffering SHALL be one sub-module, trace_fifo (synchronous, show-ahead, parameterised width and depth), instantiated once.

Verification
REQ-039 Scenario: 3 beats, pc 0x100/0x104/0x108, tlast on the 3rd, out_ready=1 -> identical beats out in order, pkt_count=1, last_pkt_len=3.
REQ-040 Scenario: out_ready=0, tvalid=1 continuously -> tready drops after exactly 8 accepts; then one pop -> exactly 1 more accept.
REQ-041 Scenario: tlast_interval=4, 5 non-last beats -> overlength_err=1 on the 4th accept; clr -> 0.
REQ-042 Scenario: beat with instr=0x10500073 and tlast=1 -> halted=1, wfi_seen=1, tready=0 while buffered beats still drain; clr -> tready=1.
REQ-043 Scenario: rst_n pulsed low after 2 of 4 beats -> all outputs 0 asynchronously; a subsequent 2-beat packet gives last_pkt_len=2.
REQ-044 Scenario: pkt_count forced to 0xFFFFFFFF, one more packet completes -> pkt_count=0.
